// File: rtl/multicycle_control_unit_pkg.sv
// Shared RV32I encodings for the multi-cycle control unit: opcodes, mux selects, FSM states.
package rv32i_pkg;

  localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
  localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
  localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
  localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
  localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
  localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
  localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
  localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
  localparam logic [6:0] OP_TYPE_JL = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  localparam logic [2:0] RFWD_ALU    = 3'd0;
  localparam logic [2:0] RFWD_BUS    = 3'd1;
  localparam logic [2:0] RFWD_IMM    = 3'd2;
  localparam logic [2:0] RFWD_PC_IMM = 3'd3;
  localparam logic [2:0] RFWD_PC_4   = 3'd4;

  typedef enum logic [2:0] {FETCH, DECODE, EXE, S_MEM, L_MEM, L_WB} state_t;

  typedef struct packed {
    logic       pc_en;
    logic       reg_file_we;
    logic       alu_src;
    logic [3:0] alu_ctl;
    logic [2:0] rfwd_sel;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       bus_we;
    logic       bus_re;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU operation decode from opcode/funct3/funct7[5]; branch condition rides in [2:0].
module alu_decoder
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic       f7_5,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (opcode)
      OP_TYPE_R: alu_control = {f7_5, f3};
      // bit30 is part of the immediate except for the shift-right pair
      OP_TYPE_I: alu_control = {(f3 == 3'b101) ? f7_5 : 1'b0, f3};
      OP_TYPE_B: alu_control = {1'b0, f3};
      default:   alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXE plus store/load memory phases.
// Optional BUS_WAIT_EN: memory states stall until busReady.
module multicycle_control_unit
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  output logic        pcEn,
  output logic        regFileWe,
  output logic        aluSrcMuxSel,
  output logic [3:0]  aluControl,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        busWe,
  output logic        busRe
);

  state_t     state, state_nxt;
  ctrl_t      ctrl, ctrl_nxt;
  logic [6:0] opcode;
  logic [3:0] alu_ctl;
  logic       is_r, is_i, is_l, is_s, is_b, is_lu, is_au, is_j, is_jl;
  logic       s_mem_done;

  assign opcode = instrCode[6:0];
  assign is_r   = (opcode == OP_TYPE_R);
  assign is_i   = (opcode == OP_TYPE_I);
  assign is_l   = (opcode == OP_TYPE_L);
  assign is_s   = (opcode == OP_TYPE_S);
  assign is_b   = (opcode == OP_TYPE_B);
  assign is_lu  = (opcode == OP_TYPE_LU);
  assign is_au  = (opcode == OP_TYPE_AU);
  assign is_j   = (opcode == OP_TYPE_J);
  assign is_jl  = (opcode == OP_TYPE_JL);

  alu_decoder u_alu_decoder (
    .opcode      (opcode),
    .f3          (instrCode[14:12]),
    .f7_5        (instrCode[30]),
    .alu_control (alu_ctl)
  );

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: state_nxt = EXE;
      EXE:    state_nxt = is_s ? S_MEM : (is_l ? L_MEM : FETCH);
`ifdef BUS_WAIT_EN
      S_MEM:  state_nxt = busReady ? FETCH : S_MEM;
      L_MEM:  state_nxt = busReady ? L_WB : L_MEM;
`else
      S_MEM:  state_nxt = FETCH;
      L_MEM:  state_nxt = L_WB;
`endif
      L_WB:   state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Outputs are registered from the state being entered, so they behave as Moore outputs.
  always_comb begin
    ctrl_nxt = '0;
    if (state_nxt != FETCH && state_nxt != DECODE) begin
      ctrl_nxt.alu_ctl  = alu_ctl;
      ctrl_nxt.alu_src  = is_i | is_l | is_s | is_jl;
      ctrl_nxt.branch   = is_b;
      ctrl_nxt.jal      = is_j | is_jl;
      ctrl_nxt.jalr     = is_jl;
      ctrl_nxt.rfwd_sel = is_l  ? RFWD_BUS :
                          is_lu ? RFWD_IMM :
                          is_au ? RFWD_PC_IMM :
                          (is_j | is_jl) ? RFWD_PC_4 : RFWD_ALU;
    end
    case (state_nxt)
      EXE: begin
        ctrl_nxt.reg_file_we = is_r | is_i | is_lu | is_au | is_j | is_jl;
        ctrl_nxt.pc_en       = !(is_l | is_s);
      end
      S_MEM: begin
        ctrl_nxt.bus_we = 1'b1;
`ifndef BUS_WAIT_EN
        ctrl_nxt.pc_en  = 1'b1;
`endif
      end
      L_MEM: ctrl_nxt.bus_re = 1'b1;
      L_WB: begin
        ctrl_nxt.bus_re      = 1'b1;
        ctrl_nxt.reg_file_we = 1'b1;
        ctrl_nxt.pc_en       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ctrl  <= '0;
    end else begin
      state <= state_nxt;
      ctrl  <= ctrl_nxt;
    end
  end

`ifdef BUS_WAIT_EN
  // Store completion depends on this cycle's busReady, so it cannot be registered.
  assign s_mem_done = (state == S_MEM) && busReady;
`else
  assign s_mem_done = 1'b0;
`endif

  // Write strobes are suppressed while reset is sampled, whatever state we were in.
  assign pcEn          = (ctrl.pc_en | s_mem_done) & ~reset;
  assign regFileWe     = ctrl.reg_file_we & ~reset;
  assign busWe         = ctrl.bus_we & ~reset;
  assign busRe         = ctrl.bus_re;
  assign aluSrcMuxSel  = ctrl.alu_src;
  assign aluControl    = ctrl.alu_ctl;
  assign RFWDSrcMuxSel = ctrl.rfwd_sel;
  assign branch        = ctrl.branch;
  assign jal           = ctrl.jal;
  assign jalr          = ctrl.jalr;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven per-cycle check of the multi-cycle control unit with a scoreboard queue.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrCode;
  logic        busReady;
  logic        pcEn, regFileWe, aluSrcMuxSel, branch, jal, jalr, busWe, busRe;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk           (clk),
    .reset         (reset),
    .instrCode     (instrCode),
    .busReady      (busReady),
    .pcEn          (pcEn),
    .regFileWe     (regFileWe),
    .aluSrcMuxSel  (aluSrcMuxSel),
    .aluControl    (aluControl),
    .RFWDSrcMuxSel (RFWDSrcMuxSel),
    .branch        (branch),
    .jal           (jal),
    .jalr          (jalr),
    .busWe         (busWe),
    .busRe         (busRe)
  );

  // {pcEn, regFileWe, aluSrc, aluControl[3:0], RFWD[2:0], branch, jal, jalr, busWe, busRe}
  typedef struct {
    string       name;
    logic [31:0] instr;
    int          lat;
    logic [3:0]  alu;
    logic        src;
    logic [2:0]  rfwd;
    logic        br, j, jr, we_exe;
  } vec_t;

  vec_t        tbl[15];
  logic [14:0] sb_q[$];

  function automatic logic [14:0] outs();
    return {pcEn, regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel,
            branch, jal, jalr, busWe, busRe};
  endfunction

  function automatic logic [14:0] expv(vec_t t, int k);
    logic pc, we, bwe, bre;
    if (k < 3) return '0;
    pc  = (k == t.lat);
    we  = (k == 3) ? t.we_exe : (t.lat == 5 && k == 5);
    bwe = (t.lat == 4 && k == 4);
    bre = (t.lat == 5 && k >= 4);
    return {pc, we, t.src, t.alu, t.rfwd, t.br, t.j, t.jr, bwe, bre};
  endfunction

  task automatic check(string name, logic [14:0] act, logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction through cycles 1..ncyc, checking each against the scoreboard.
  task automatic run_instr(vec_t t, int ncyc);
    logic [14:0] e;
    instrCode = t.instr;
    for (int k = 1; k <= ncyc; k++) begin
      sb_q.push_back(expv(t, k));
      @(negedge clk);
      e = sb_q.pop_front();
      check($sformatf("%s c%0d", t.name, k), outs(), e);
      if (k < ncyc) next_cycle();
    end
    next_cycle();
  endtask

  task automatic reset_in_cycle(vec_t t, int rst_cyc, string name);
    run_instr(t, rst_cyc - 1);
    reset = 1'b1;
    @(negedge clk);
    check({name, " strobes"}, outs() & 15'b110000000000010, 15'b0);
    next_cycle();
    @(negedge clk);
    check({name, " after"}, outs(), 15'b0);
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{"addi5",   32'h00500093, 3, 4'b0000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{"addi400", 32'h40000093, 3, 4'b0000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{"srai",    32'h4020D093, 3, 4'b1101, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{"sub",     32'h402081B3, 3, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{"lw",      32'h0080A203, 5, 4'b0000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{"sw",      32'h0020A423, 4, 4'b0000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{"beq",     32'h00208463, 3, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{"jal",     32'h010000EF, 3, 4'b0000, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{"jalr",    32'h000100E7, 3, 4'b0000, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{"lui",     32'h123452B7, 3, 4'b0000, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{"auipc",   32'h00001297, 3, 4'b0000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{"illegal", 32'h0000007F, 3, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{"bne",     32'h00209463, 3, 4'b0001, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{"slti",    32'h0020A093, 3, 4'b0010, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{"sra",     32'h4020D1B3, 3, 4'b1101, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset     = 1'b1;
    busReady  = 1'b1;
    instrCode = 32'h00500093;
    repeat (2) next_cycle();
    @(negedge clk);
    check("reset state", outs(), 15'b0);
    next_cycle();
    reset = 1'b0;

    foreach (tbl[i]) run_instr(tbl[i], tbl[i].lat);

    // reset mid-load, mid-writeback and mid-store: no strobe, clean FETCH afterwards
    reset_in_cycle(tbl[4], 4, "rst L_MEM");
    run_instr(tbl[0], 3);
    reset_in_cycle(tbl[4], 5, "rst L_WB");
    run_instr(tbl[3], 3);
    reset_in_cycle(tbl[5], 4, "rst S_MEM");
    run_instr(tbl[4], 5);

`ifdef BUS_WAIT_EN
    // load with busReady low for three cycles: L_MEM stretches to four cycles
    begin
      logic [14:0] lmem, lwb;
      lmem = expv(tbl[4], 4);
      lwb  = expv(tbl[4], 5);
      run_instr(tbl[4], 3);
      busReady = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (k == 3) busReady = 1'b1;
        sb_q.push_back(lmem);
        @(negedge clk);
        check($sformatf("lw wait L_MEM %0d", k), outs(), sb_q.pop_front());
        next_cycle();
      end
      sb_q.push_back(lwb);
      @(negedge clk);
      check("lw wait L_WB", outs(), sb_q.pop_front());
      next_cycle();
    end
`endif

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
